pipelined_csel_subtractor_16: RTL and testbench



---
 rtl/pipelined_csel_subtractor_16.sv | 172 +++++++++++++++++
 tb/tb_pipelined_csel_subtractor_16.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_subtractor_16.sv
// rtl/pipelined_csel_subtractor_16.sv - two-stage carry-select subtractor with valid/ready handshakes
// Computes a + ~b + ~bin; stage 1 resolves the low half, stage 2 selects the precomputed high blocks.
module pipelined_csel_subtractor_16 #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;
    localparam int NBLK = HALF / BLOCK;

    logic                         s1_valid_q, s1_valid_d;
    logic [HALF-1:0]              s1_lo_q, s1_lo_d;
    logic                         s1_carry_q, s1_carry_d;
    logic [NBLK-1:0][BLOCK-1:0]   s1_sum0_q, s1_sum0_d;
    logic [NBLK-1:0][BLOCK-1:0]   s1_sum1_q, s1_sum1_d;
    logic [NBLK-1:0]              s1_co0_q, s1_co0_d;
    logic [NBLK-1:0]              s1_co1_q, s1_co1_d;
    logic                         s1_amsb_q, s1_amsb_d;
    logic                         s1_bmsb_q, s1_bmsb_d;

    logic                         s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]             diff_q, diff_d;
    logic                         bout_q, bout_d;
    logic                         ovf_q, ovf_d;

    logic                         s2_adv;
    logic                         in_xfer;
    logic [WIDTH-1:0]             b_inv;
    logic [HALF-1:0]              lo_diff;
    logic                         lo_carry;
    logic [BLOCK:0]               t0, t1;
    logic [NBLK-1:0][BLOCK-1:0]   cand_sum0, cand_sum1;
    logic [NBLK-1:0]              cand_co0, cand_co1;
    logic [HALF-1:0]              hi_diff;
    logic                         hi_carry;

    assign s2_adv    = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || s2_adv;
    assign in_xfer   = in_valid && in_ready;
    assign b_inv     = ~b;
    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

    // Low half ripples block to block; high blocks get both carry-in candidates.
    always_comb begin
        lo_diff   = '0;
        lo_carry  = ~bin;
        t0        = '0;
        t1        = '0;
        cand_sum0 = '0;
        cand_sum1 = '0;
        cand_co0  = '0;
        cand_co1  = '0;
        for (int i = 0; i < NBLK; i++) begin
            t0 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b_inv[i*BLOCK +: BLOCK]};
            t1 = t0 + {{BLOCK{1'b0}}, 1'b1};
            if (lo_carry) begin
                lo_diff[i*BLOCK +: BLOCK] = t1[BLOCK-1:0];
                lo_carry                  = t1[BLOCK];
            end else begin
                lo_diff[i*BLOCK +: BLOCK] = t0[BLOCK-1:0];
                lo_carry                  = t0[BLOCK];
            end
        end
        for (int j = 0; j < NBLK; j++) begin
            {cand_co0[j], cand_sum0[j]} = {1'b0, a[HALF + j*BLOCK +: BLOCK]}
                                        + {1'b0, b_inv[HALF + j*BLOCK +: BLOCK]};
            {cand_co1[j], cand_sum1[j]} = {cand_co0[j], cand_sum0[j]} + {{BLOCK{1'b0}}, 1'b1};
        end
    end

    always_comb begin
        hi_diff  = '0;
        hi_carry = s1_carry_q;
        for (int j = 0; j < NBLK; j++) begin
            if (hi_carry) begin
                hi_diff[j*BLOCK +: BLOCK] = s1_sum1_q[j];
                hi_carry                  = s1_co1_q[j];
            end else begin
                hi_diff[j*BLOCK +: BLOCK] = s1_sum0_q[j];
                hi_carry                  = s1_co0_q[j];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_carry_d = s1_carry_q;
        s1_sum0_d  = s1_sum0_q;
        s1_sum1_d  = s1_sum1_q;
        s1_co0_d   = s1_co0_q;
        s1_co1_d   = s1_co1_q;
        s1_amsb_d  = s1_amsb_q;
        s1_bmsb_d  = s1_bmsb_q;
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;

        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_lo_d    = lo_diff;
            s1_carry_d = lo_carry;
            s1_sum0_d  = cand_sum0;
            s1_sum1_d  = cand_sum1;
            s1_co0_d   = cand_co0;
            s1_co1_d   = cand_co1;
            s1_amsb_d  = a[WIDTH-1];
            s1_bmsb_d  = b[WIDTH-1];
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = 1'b1;
            diff_d     = {hi_diff, s1_lo_q};
            bout_d     = ~hi_carry;
            ovf_d      = (s1_amsb_q != s1_bmsb_q) && (hi_diff[HALF-1] != s1_amsb_q);
        end else if (s2_valid_q && out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_carry_q <= 1'b0;
            s1_sum0_q  <= '0;
            s1_sum1_q  <= '0;
            s1_co0_q   <= '0;
            s1_co1_q   <= '0;
            s1_amsb_q  <= 1'b0;
            s1_bmsb_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lo_q    <= s1_lo_d;
            s1_carry_q <= s1_carry_d;
            s1_sum0_q  <= s1_sum0_d;
            s1_sum1_q  <= s1_sum1_d;
            s1_co0_q   <= s1_co0_d;
            s1_co1_q   <= s1_co1_d;
            s1_amsb_q  <= s1_amsb_d;
            s1_bmsb_q  <= s1_bmsb_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_csel_subtractor_16.sv
// tb/tb_pipelined_csel_subtractor_16.sv - self-checking bench for pipelined_csel_subtractor_16
module tb_pipelined_csel_subtractor_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    pipelined_csel_subtractor_16 #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t tbl [7];
    res_t exp_q [$];
    res_t cur_exp;
    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;

    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        res_t        r;
        logic [16:0] full;
        full   = {1'b0, ma} - {1'b0, mb} - {16'b0, mbin};
        r.diff = full[15:0];
        r.bout = full[16];
        r.ovf  = (ma[15] != mb[15]) && (r.diff[15] != ma[15]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] da, input logic [15:0] db,
                         input logic dbin, input logic ordy);
        in_valid  = v;
        a         = da;
        b         = db;
        bin       = dbin;
        out_ready = ordy;
        cur_exp   = model(da, db, dbin);
    endtask

    // Called at a falling edge after inputs are set; accounts for transfers at the next rising edge.
    task automatic step();
        res_t e;
        #1;
        if (in_valid && in_ready) exp_q.push_back(cur_exp);
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("diff", 32'(diff), 32'(e.diff));
                chk("bout", 32'(bout), 32'(e.bout));
                chk("ovf",  32'(ovf),  32'(e.ovf));
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int cycles);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        repeat (cycles) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb, ha, hb;
        logic        rbin, hbin;
        int          base;

        tbl[0] = '{16'hFCFF, 16'hFFF0, 1'b1, 16'hFD0E, 1'b1, 1'b0};
        tbl[1] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[3] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff",      32'(diff),      32'd0);
        chk("rst_bout",      32'(bout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);

        // Directed vectors with latency checks
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].bin, 1'b1);
            cur_exp = '{tbl[i].diff, tbl[i].bout, tbl[i].ovf};
            #1 chk("tbl_in_ready", 32'(in_ready), 32'd1);
            step();
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            #1 chk("tbl_lat1_out_valid", 32'(out_valid), 32'd0);
            step();
            #1 chk("tbl_lat2_out_valid", 32'(out_valid), 32'd1);
            step();
        end
        chk("tbl_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: three beats offered while the sink stalls
        base = n_out;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b0);
            #1 chk("bp_accept_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        ha   = 16'($urandom());
        hb   = 16'($urandom());
        hbin = 1'($urandom());
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ha, hb, hbin, 1'b0);
            #1;
            chk("bp_in_ready_low", 32'(in_ready),  32'd0);
            chk("bp_out_valid",    32'(out_valid), 32'd1);
            chk("bp_head_diff",    32'(diff),      32'(exp_q[0].diff));
            chk("bp_head_bout",    32'(bout),      32'(exp_q[0].bout));
            step();
        end
        drive(1'b1, ha, hb, hbin, 1'b1);
        #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        drain(5);
        chk("bp_result_count", 32'(n_out - base), 32'd3);

        // Streaming at full rate
        base = n_out;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b1);
            #1;
            if (i >= 2) chk("stream_out_valid", 32'(out_valid), 32'd1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        drain(5);
        chk("stream_result_count", 32'(n_out - base), 32'd100);

        // Random handshakes on both sides
        for (int i = 0; i < 400; i++) begin
            ra   = 16'($urandom());
            rb   = (i % 5 == 0) ? ra : 16'($urandom());
            rbin = 1'($urandom());
            drive(1'($urandom_range(0, 1)), ra, rb, rbin, ($urandom_range(0, 3) != 0));
            step();
        end
        drain(6);

        // Reset with two beats in flight
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'($urandom()), 16'($urandom()), 1'b0, 1'b0);
            step();
        end
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_diff",      32'(diff),      32'd0);
        base = n_out;
        drive(1'b1, 16'h1234, 16'h0234, 1'b0, 1'b1);
        cur_exp = '{16'h1000, 1'b0, 1'b0};
        step();
        drain(5);
        chk("midrst_result_count", 32'(n_out - base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
